// File: rtl/load_store_unit.sv
// load_store_unit
// MEM-stage load/store unit in front of a 32-bit word memory with a
// combinational read port and a clocked write port.
//
// Loads are served combinationally with byte/halfword lane selection and
// sign or zero extension. Aligned word stores write in the same cycle.
// Byte and halfword stores take a read-modify-write path:
//   - IDLE: stall one cycle and capture the addressed word.
//   - MERGE: write the merged word back.
//
// Ports
//   clk, rst               : clock and synchronous active-high reset
//   MemReadM, MemWriteM    : load / store request (store wins if both)
//   funct3M                : 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM             : byte address of the access
//   WriteDataM             : right-justified store data
//   ReadDataM              : extended load result
//   StallM                 : hold the MEM stage this cycle
//   MisalignM              : current access is misaligned
//   mem_addr               : word-aligned byte address to memory
//   mem_wdata, mem_we      : write word and write enable
//   mem_rdata              : combinational read data of mem_addr
//   state_o                : debug view of the FSM state (0 IDLE, 1 MERGE)
//
// Handshake: there is no valid/ready pair here. A request is presented by
// holding MemReadM/MemWriteM and its operands for a cycle. When StallM is 1,
// the pipeline must present the same request again on the next cycle. The
// access completes in the first cycle where StallM is 0.
module load_store_unit #(
  parameter int ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        state_o
);

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  // Clears the byte-offset bits so the memory always sees a word address.
  localparam logic [31:0] WORD_MASK = ~((32'd1 << ADDR_LSB) - 32'd1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;   // sign bit is irrelevant for stores
  logic [15:0] wdata_q;  // only the low halfword can reach memory
  logic [31:0] merge_q;

  logic        load_ok, store_ok, access_mis, sub_go;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] merged_word;

  assign state_o = state_q;

  // Legal encodings for each direction; anything else is a silent no-op.
  assign load_ok  = (funct3M == 3'b000) || (funct3M == 3'b001) ||
                    (funct3M == 3'b010) || (funct3M == 3'b100) ||
                    (funct3M == 3'b101);
  assign store_ok = (funct3M == 3'b000) || (funct3M == 3'b001) ||
                    (funct3M == 3'b010);

  // Halfword accesses need addr[0]==0, word accesses addr[1:0]==00.
  assign access_mis = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                      ((funct3M == 3'b010) && (ALUResultM[1:0] != 2'b00));

  // A legal, aligned byte/halfword store starts the read-modify-write.
  assign sub_go = (state_q == IDLE) && MemWriteM && store_ok && !access_mis &&
                  (funct3M[1:0] != 2'b10);

  assign ld_byte = mem_rdata[{ALUResultM[1:0], 3'b000} +: 8];
  assign ld_half = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    merged_word = merge_q;
    if (size_q == 2'b00) begin
      merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    ReadDataM = 32'd0;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ALUResultM & WORD_MASK;
    mem_wdata = WriteDataM;
    if (state_q == MERGE) begin
      // Only latched values are used here; live inputs are ignored.
      mem_addr  = addr_q & WORD_MASK;
      mem_wdata = merged_word;
      mem_we    = 1'b1;
    end else if (MemWriteM) begin
      if (store_ok) begin
        if (access_mis) begin
          MisalignM = 1'b1;
        end else if (funct3M[1:0] == 2'b10) begin
          mem_we = 1'b1;
        end else begin
          StallM = 1'b1;
        end
      end
    end else if (MemReadM && load_ok) begin
      if (access_mis) begin
        MisalignM = 1'b1;
      end else begin
        case (funct3M[1:0])
          2'b00:   ReadDataM = {{24{~funct3M[2] & ld_byte[7]}}, ld_byte};
          2'b01:   ReadDataM = {{16{~funct3M[2] & ld_half[15]}}, ld_half};
          default: ReadDataM = mem_rdata;
        endcase
      end
    end
    // Reset suppresses any write, including one from an aborted MERGE.
    if (rst) begin
      StallM = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      wdata_q <= 16'd0;
      merge_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sub_go) begin
            state_q <= MERGE;
            addr_q  <= ALUResultM;
            size_q  <= funct3M[1:0];
            wdata_q <= WriteDataM[15:0];
            merge_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_LSB, default 2: index of the lowest word-address bit sent to memory; the memory port addresses 32-bit words.
REQ-002 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have MemReadM, input, 1: load request from the MEM stage.
REQ-005 SHALL have MemWriteM, input, 1: store request from the MEM stage.
REQ-006 SHALL have funct3M, input, 3: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have ALUResultM, input, 32: byte address.
REQ-008 SHALL have WriteDataM, input, 32: store data, right-justified.
REQ-009 SHALL have ReadDataM, output, 32: extended load result.
REQ-010 SHALL have StallM, output, 1: the pipeline must hold the MEM stage and its inputs this cycle.
REQ-011 SHALL have MisalignM, output, 1: current access is misaligned.
REQ-012 SHALL have mem_addr, output, 32: byte address to the word memory, always {ALUResultM[31:2],2'b00} in IDLE and the latched address in MERGE.
REQ-013 SHALL have mem_wdata, output, 32: full word to write.
REQ-014 SHALL have mem_we, output, 1: word write enable; the memory writes on the clk edge.
REQ-015 SHALL have mem_rdata, input, 32: combinational read data of the word at mem_addr.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and MERGE; IDLE is the reset state.
REQ-017 SHALL produce loads combinationally in IDLE with zero latency and no stall.
REQ-018 SHALL select the byte lane as addr[1:0] and the halfword lane as addr[1].
REQ-019 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results; LW passes the word through.
REQ-020 SHALL perform an aligned SW in the same cycle: mem_we=1, mem_wdata=WriteDataM, StallM=0.
REQ-021 SHALL handle an aligned SB/SH in IDLE as follows: assert StallM=1 and mem_we=0; latch address, funct3, and WriteDataM; latch mem_rdata into the merge register; go to MERGE.
REQ-022 SHALL, in MERGE, write the merge word with the target lane replaced by WriteDataM[7:0] or [15:0], with mem_we=1 and StallM=0, then return to IDLE.
REQ-023 SHALL use only the latched values in MERGE, ignoring any input changes.
REQ-024 SHALL give a sub-word store a latency of 2 cycles (1 stall cycle); back-to-back sub-word stores each stall for 1 cycle.
REQ-025 SHALL flag as misaligned: H/HU/SH with addr[0]=1, and W/SW with addr[1:0]!=00.
REQ-026 SHALL, on a misaligned access, drive MisalignM=1 combinationally, mem_we=0, StallM=0, ReadDataM=0, and keep the FSM in IDLE.
REQ-027 SHALL treat funct3 values 011, 110, and 111 as a no-op: mem_we=0, ReadDataM=0, MisalignM=0, no stall; stores with funct3 100 or 101 are also a no-op.
REQ-028 SHALL give the write priority when MemReadM and MemWriteM are both 1; ReadDataM=0 in that case.
REQ-029 SHALL drive ReadDataM=0, MisalignM=0, and mem_we=0 when neither request is asserted.
REQ-030 SHALL drive ReadDataM=0 in MERGE.

Reset
REQ-031 SHALL, while rst=1, force state to IDLE, clear the merge register and latched fields to 0, and drive StallM=0 and mem_we=0 regardless of inputs.
REQ-032 SHALL abort an in-progress MERGE when rst asserts: no memory write occurs at that edge, and after rst deasserts the FSM is in IDLE.

Verification
REQ-033 SHALL cover byte loads: mem word 0x10=0xAABBCCDD; LB 0x13 -> ReadDataM=0xFFFFFFAA; LBU 0x13 -> 0x000000AA; LB 0x10 -> 0xFFFFFFDD; StallM=0 throughout.
REQ-034 SHALL cover halfword loads: same word; LH 0x12 -> 0xFFFFAABB; LHU 0x10 -> 0x0000CCDD; LH 0x11 -> MisalignM=1, ReadDataM=0.
REQ-035 SHALL cover a byte store: SB 0x11, WriteDataM=0x12345677 -> StallM=1 for exactly 1 cycle, mem_we=1 in the next cycle; word 0x10 becomes 0xAABB77DD.
REQ-036 SHALL cover word stores: SW 0x14 with 0xDEADBEEF -> written at the same edge, no stall; SW 0x16 -> MisalignM=1, word 0x14 unchanged.
REQ-037 SHALL cover reset mid-store: SH 0x12 with 0x00009999, rst=1 in the MERGE cycle -> word 0x10 unchanged at 0xAABBCCDD; StallM=0 and state IDLE after release.
REQ-038 SHALL cover simultaneous requests: MemReadM=MemWriteM=1 with SW 0x18 and 0x01020304 -> word written, ReadDataM=0.
